// File: rtl/bram_stream_reader.sv
// rtl/bram_stream_reader.sv - Port-A read initiator streaming a wrapping word run through a credit-based skid FIFO
module bram_stream_reader #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 5,
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_rden,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + RD_LAT + 1);
    localparam logic [ADDR_W:0] LEN_ONE = (ADDR_W + 1)'(1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W:0]     len_q, len_d;
    logic [ADDR_W:0]     issued_q, issued_d;
    logic                done_q, done_d;
    logic [RD_LAT-1:0]   pipe_v_q, pipe_l_q;
    logic [DATA_W-1:0]   fifo_data_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] fifo_last_q;
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]    fifo_count_q;
    logic [CNT_W-1:0]    inflight;
    logic                credit, issue, issue_last, push, pop, fifo_valid;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + CNT_W'(pipe_v_q[i]);
        end
    end

    // Reads in flight reserve a FIFO slot, so the FIFO can never overflow.
    assign credit     = (inflight + fifo_count_q) < CNT_W'(FIFO_DEPTH);
    assign issue      = (state_q == RUN) && credit;
    assign issue_last = issue && ((issued_q + LEN_ONE) == len_q);
    assign push       = pipe_v_q[RD_LAT-1];
    assign fifo_valid = (fifo_count_q != '0);
    assign pop        = fifo_valid && out_ready;

    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign mem_address = addr_q;
    assign mem_rden    = issue;
    assign mem_wren    = 1'b0;
    assign out_valid   = fifo_valid;
    assign out_data    = fifo_valid ? fifo_data_q[rd_ptr_q] : '0;
    assign out_last    = fifo_valid && fifo_last_q[rd_ptr_q];

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        len_d    = len_q;
        issued_d = issued_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        addr_d   = base_addr;
                        len_d    = len;
                        issued_d = '0;
                        state_d  = RUN;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (issue) begin
                    addr_d   = addr_q + ADDR_W'(1);
                    issued_d = issued_q + LEN_ONE;
                    if (issue_last) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && out_last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            len_q    <= '0;
            issued_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            issued_q <= issued_d;
            done_q   <= done_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pipe_v_q     <= '0;
            pipe_l_q     <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_data_q[i] <= '0;
            fifo_last_q  <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_count_q <= '0;
        end else begin
            pipe_v_q[0] <= issue;
            pipe_l_q[0] <= issue_last;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_v_q[i] <= pipe_v_q[i-1];
                pipe_l_q[i] <= pipe_l_q[i-1];
            end
            // mem_q is valid exactly when the tag leaves the pipe.
            if (push) begin
                fifo_data_q[wr_ptr_q] <= mem_q;
                fifo_last_q[wr_ptr_q] <= pipe_l_q[RD_LAT-1];
                wr_ptr_q              <= ptr_inc(wr_ptr_q);
            end
            if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (push && !pop)      fifo_count_q <= fifo_count_q + CNT_W'(1);
            else if (!push && pop) fifo_count_q <= fifo_count_q - CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_bram_stream_reader.sv
// tb/tb_bram_stream_reader.sv - Directed self-checking bench for bram_stream_reader
module tb_bram_stream_reader;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 5;

    logic              clock, reset, start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   len;
    logic              busy, done, mem_rden, mem_wren;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_q, out_data;
    logic              out_valid, out_ready, out_last;

    bram_stream_reader #(.DATA_W(16), .ADDR_W(5), .RD_LAT(2), .FIFO_DEPTH(4)) dut (
        .clock(clock), .reset(reset), .start(start), .base_addr(base_addr), .len(len),
        .busy(busy), .done(done), .mem_address(mem_address), .mem_rden(mem_rden),
        .mem_wren(mem_wren), .mem_q(mem_q), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Registered-output buffer model, two cycles of read latency.
    logic [DATA_W-1:0] image [32];
    logic [DATA_W-1:0] ram_r1;
    initial for (int i = 0; i < 32; i++) image[i] = 16'h0100 + 16'(i);
    always @(posedge clock) begin
        if (mem_rden) ram_r1 <= image[mem_address];
        mem_q <= ram_r1;
    end

    int rd_cyc[$], rd_addr[$], hs_cyc[$], hs_last[$], done_cyc[$], busy_rise[$], busy_fall[$];
    logic [DATA_W-1:0] hs_data[$];
    int stall_err = 0;
    int wren_seen = 0;
    logic prev_busy = 1'b0, prev_stall = 1'b0, prev_last = 1'b0;
    logic [DATA_W-1:0] prev_data = '0;

    always @(negedge clock) begin
        if (reset) begin
            prev_stall <= 1'b0;
            prev_busy  <= 1'b0;
        end else begin
            if (mem_rden) begin
                rd_cyc.push_back(cyc);
                rd_addr.push_back(int'(mem_address));
            end
            if (out_valid && out_ready) begin
                hs_cyc.push_back(cyc);
                hs_data.push_back(out_data);
                hs_last.push_back(int'(out_last));
            end
            if (done) done_cyc.push_back(cyc);
            if (mem_wren) wren_seen <= wren_seen + 1;
            if (prev_stall && (!out_valid || out_data !== prev_data || out_last !== prev_last))
                stall_err <= stall_err + 1;
            prev_stall <= out_valid && !out_ready;
            prev_data  <= out_data;
            prev_last  <= out_last;
            if (busy && !prev_busy) busy_rise.push_back(cyc);
            if (!busy && prev_busy) busy_fall.push_back(cyc);
            prev_busy <= busy;
        end
    end

    int n_checks = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic clear_logs();
        rd_cyc.delete(); rd_addr.delete(); hs_cyc.delete(); hs_last.delete();
        hs_data.delete(); done_cyc.delete(); busy_rise.delete(); busy_fall.delete();
    endtask

    task automatic do_start(input int base, input int n, output int s);
        base_addr = ADDR_W'(base);
        len       = (ADDR_W + 1)'(n);
        start     = 1'b1;
        s         = cyc;
        step(1);
        start     = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (done_cyc.size() == 0 && k < budget) begin
            step(1);
            k++;
        end
        check_eq("done_seen", 32'(done_cyc.size() != 0), 1);
        step(4);
    endtask

    task automatic check_run(input string tag, input int base, input int n, input int s, input bit timed);
        check_eq({tag, "_rd_count"}, rd_addr.size(), n);
        for (int i = 0; i < n && i < rd_addr.size(); i++) begin
            check_eq({tag, "_rd_addr"}, rd_addr[i], (base + i) % 32);
            if (timed) check_eq({tag, "_rd_cyc"}, rd_cyc[i], s + 1 + i);
        end
        check_eq({tag, "_hs_count"}, hs_data.size(), n);
        for (int i = 0; i < n && i < hs_data.size(); i++) begin
            check_eq({tag, "_data"}, 32'(hs_data[i]), 32'h100 + (base + i) % 32);
            check_eq({tag, "_last"}, hs_last[i], 32'(i == n - 1));
            if (timed) check_eq({tag, "_hs_cyc"}, hs_cyc[i], s + 4 + i);
        end
        check_eq({tag, "_done_count"}, done_cyc.size(), 1);
        if (timed && done_cyc.size() > 0) check_eq({tag, "_done_cyc"}, done_cyc[0], s + n + 4);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int s;
        int snap;
        reset = 1'b1; start = 1'b0; base_addr = '0; len = '0; out_ready = 1'b1;
        #2;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_rden", mem_rden, 0);
        check_eq("rst_addr", mem_address, 0);
        check_eq("rst_wren", mem_wren, 0);
        check_eq("rst_valid", out_valid, 0);
        check_eq("rst_last", out_last, 0);
        check_eq("rst_data", out_data, 0);
        step(2);
        reset = 1'b0;
        step(2);

        clear_logs();
        do_start(0, 4, s);
        wait_done(50);
        check_run("basic", 0, 4, s, 1);
        check_eq("basic_busy_rise_n", busy_rise.size(), 1);
        if (busy_rise.size() > 0) check_eq("basic_busy_rise", busy_rise[0], s + 1);
        check_eq("basic_busy_fall_n", busy_fall.size(), 1);
        if (busy_fall.size() > 0) check_eq("basic_busy_fall", busy_fall[0], s + 8);

        clear_logs();
        do_start(30, 4, s);
        wait_done(50);
        check_run("wrap", 30, 4, s, 1);

        clear_logs();
        snap = stall_err;
        out_ready = 1'b0;
        do_start(0, 16, s);
        step(11);
        check_eq("bp_rd_stop", rd_addr.size(), 4);
        check_eq("bp_valid", out_valid, 1);
        check_eq("bp_hold_data", out_data, 32'h0100);
        check_eq("bp_hold_last", out_last, 0);
        out_ready = 1'b1;
        wait_done(200);
        check_run("bp", 0, 16, s, 0);
        if (hs_cyc.size() > 0) check_eq("bp_first_hs", hs_cyc[0], s + 12);
        for (int i = 1; i < hs_cyc.size(); i++) check_eq("bp_no_gap", hs_cyc[i], hs_cyc[0] + i);
        check_eq("bp_stable", stall_err - snap, 0);

        clear_logs();
        snap = stall_err;
        out_ready = 1'($urandom_range(0, 1));
        do_start(7, 32, s);
        for (int k = 0; k < 3000 && done_cyc.size() == 0; k++) begin
            out_ready = 1'($urandom_range(0, 1));
            step(1);
        end
        out_ready = 1'b1;
        wait_done(20);
        check_run("rand", 7, 32, s, 0);
        check_eq("rand_stable", stall_err - snap, 0);

        clear_logs();
        do_start(3, 0, s);
        step(4);
        check_eq("len0_done_n", done_cyc.size(), 1);
        if (done_cyc.size() > 0) check_eq("len0_done_cyc", done_cyc[0], s + 1);
        check_eq("len0_no_rden", rd_addr.size(), 0);
        check_eq("len0_no_busy", busy_rise.size(), 0);

        clear_logs();
        do_start(0, 8, s);
        step(2);
        base_addr = 5'd10; len = 6'd3; start = 1'b1;
        step(1);
        start = 1'b0;
        wait_done(100);
        check_run("restart_ignored", 0, 8, s, 1);

        clear_logs();
        do_start(0, 16, s);
        step(3);
        check_eq("mid_busy", busy, 1);
        check_eq("mid_valid", out_valid, 1);
        check_eq("mid_rden", mem_rden, 1);
        reset = 1'b1;
        #1;
        check_eq("arst_busy", busy, 0);
        check_eq("arst_done", done, 0);
        check_eq("arst_rden", mem_rden, 0);
        check_eq("arst_addr", mem_address, 0);
        check_eq("arst_wren", mem_wren, 0);
        check_eq("arst_valid", out_valid, 0);
        check_eq("arst_last", out_last, 0);
        check_eq("arst_data", out_data, 0);
        clear_logs();
        step(2);
        reset = 1'b0;
        step(6);
        check_eq("arst_no_done", done_cyc.size(), 0);
        check_eq("arst_no_hs", hs_data.size(), 0);
        check_eq("arst_no_rden", rd_addr.size(), 0);

        clear_logs();
        do_start(5, 6, s);
        wait_done(50);
        check_run("post_reset", 5, 6, s, 1);

        check_eq("wren_never", wren_seen, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/bram_stream_reader.md
Name: bram_stream_reader

Overview:
Read-side initiator for the 32x16 dual-port feature buffer. Drives port A of the buffer (address_a, rden_a, wren_a) to fetch a contiguous, wrapping run of words and presents them as a valid/ready stream to the CNN datapath. A credit-based skid FIFO absorbs the fixed RAM read latency, so downstream backpressure never drops or duplicates a word.

Parameters:
- DATA_W, 16, word width of buffer data and stream data.
- ADDR_W, 5, buffer address width; the buffer holds 2^ADDR_W words.
- RD_LAT, 2, cycles from rden_a/address_a sampled to valid q_a (registered-output RAM).
- FIFO_DEPTH, 4, skid FIFO entries; must be >= RD_LAT+1.

Ports:
- clock  in  1  single clock for the whole block.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- base_addr  in  ADDR_W  first word address, captured on start.
- len  in  ADDR_W+1  word count, 0..2^ADDR_W, captured on start.
- busy  out  1  high from the accepted start until done.
- done  out  1  one-cycle pulse when the run completes.
- mem_address  out  ADDR_W  to buffer address_a.
- mem_rden  out  1  to buffer rden_a.
- mem_wren  out  1  to buffer wren_a; constant 0.
- mem_q  in  DATA_W  from buffer q_a.
- out_data  out  DATA_W  stream word.
- out_valid  out  1  stream word valid.
- out_ready  in  1  downstream accept.
- out_last  out  1  high with the final word of a run.

Behaviour:
- Reset (asynchronous assert): busy=0, done=0, mem_rden=0, mem_address=0, mem_wren=0, out_valid=0, out_last=0, out_data=0. The FIFO, in-flight pipeline, counters and FSM clear immediately. Reset mid-run abandons the run with no done pulse.
- FSM states: IDLE, RUN, DRAIN.
- IDLE:
  - start=1 with len>0: capture base_addr and len, go to RUN, busy=1.
  - start=1 with len=0: done pulses on the next cycle. busy stays 0 and no read is issued.
- RUN:
  - Issue one read per cycle when credit is available: inflight + fifo_count < FIFO_DEPTH.
  - Each read drives mem_address = current address and mem_rden=1. The address then increments mod 2^ADDR_W, so 31 wraps to 0.
  - When the issued count reaches len, go to DRAIN and hold mem_rden=0.
- In-flight tracking: a RD_LAT-deep shift register carries each rden plus an is_last tag. When a tag exits, mem_q is written to the FIFO in that same cycle.
- FIFO:
  - Registered show-ahead output: a word written in cycle t can appear on out_valid in cycle t+1.
  - A pop occurs on out_valid & out_ready.
  - Simultaneous push and pop in one cycle are both honoured.
  - The credit rule guarantees no overflow, so no push is ever dropped.
- out_last accompanies the word tagged is_last (the len-th word).
- DRAIN: when the last word is popped, pulse done for one cycle in the following cycle, drop busy in that same cycle, and return to IDLE.
- start while busy=1 is ignored; base_addr and len are not recaptured.
- Stream rules: out_data and out_last stay stable while out_valid=1 and out_ready=0.
- Timing with out_ready=1 held:
  - First mem_rden is in cycle S+1, where S is the start cycle.
  - First out_valid is in cycle S+RD_LAT+2.
  - Throughput is one word per cycle after that.
- len=2^ADDR_W (32) reads every word once, starting at base_addr.

Test Plan:
- Basic run: preload word i = 16'h0100+i; start, base=0, len=4, out_ready=1. Required: rden in cycles S+1..S+4 with addresses 0,1,2,3; out_data 0100,0101,0102,0103 in cycles S+4..S+7; out_last high only with 0103; done pulses in S+8; busy falls in S+8.
- Wrap: base=30, len=4. Required: addresses 30,31,0,1; data 011E,011F,0100,0101 in that order; last word tagged.
- Backpressure: len=16, out_ready=0 for the first 12 cycles after start. Required: mem_rden stops after 4 reads; out_data stays stable at 0100 throughout the stall; after release, all 16 words arrive in order with no gaps or duplicates.
- Random backpressure: len=32, out_ready randomized at 50%. Required: exactly 32 handshakes, data matches the buffer image, exactly one done pulse.
- len=0 and start while busy: len=0 gives done one cycle later and no rden. A second start mid-run with base=10 is ignored, and the original run completes unchanged.
- Reset mid-run: assert reset during RUN with 3 reads in flight. Required: all outputs go to 0 immediately, with no done pulse. A fresh start after release yields a correct run.
